// File: rtl/cnn_frame_streamer_pkg.sv
// Shared constants, types and FSM encoding for the CNN frame streamer.
package cnn_frame_streamer_pkg;

  localparam int unsigned IMG_W  = 32;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RES_W  = 48;
  localparam int unsigned N_PIX  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = $clog2(N_PIX);

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [RES_W-1:0] result_t;

  // Host write request into the frame RAM.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    pix_t              data;
  } wr_req_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PREF,
    STREAM,
    WAIT_RES
  } strm_state_t;

endpackage

// File: rtl/cnn_frame_streamer_if.sv
// Pixel/result link between the frame streamer (master) and CNN_TOP (slave).
//   cnn_start        : 1-cycle start pulse to CNN_TOP.start_signal
//   cnn_pixel_valid  : pixel beat qualifier
//   cnn_pixel        : pixel value, 0 while not valid
//   cnn_result_valid : CNN_TOP.final_result_valid
//   cnn_result       : CNN_TOP.final_lane_result (signed)
interface cnn_frame_streamer_if;
  import cnn_frame_streamer_pkg::*;

  logic    cnn_start;
  logic    cnn_pixel_valid;
  pix_t    cnn_pixel;
  logic    cnn_result_valid;
  result_t cnn_result;

  modport master (
    output cnn_start,
    output cnn_pixel_valid,
    output cnn_pixel,
    input  cnn_result_valid,
    input  cnn_result
  );

  modport slave (
    input  cnn_start,
    input  cnn_pixel_valid,
    input  cnn_pixel,
    output cnn_result_valid,
    output cnn_result
  );

endinterface

// File: rtl/cnn_frame_streamer_frame_ram.sv
// Frame store: one host write port, one synchronous read port (1-cycle latency).
// Contents are deliberately not reset so a loaded frame survives a reset.
//   clk       : clock
//   we_i      : write enable
//   wr_i      : write address/data
//   re_i      : read enable
//   rd_addr_i : read address
//   rd_data_o : registered read data
module cnn_frame_ram
  import cnn_frame_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  wr_req_t           wr_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output pix_t              rd_data_o
);

  pix_t mem_q [N_PIX];
  pix_t rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_i.addr] <= wr_i.data;
    if (re_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/cnn_frame_streamer.sv
// Transmit side of the CNN_TOP pixel interface: holds a host-loaded frame,
// streams it row-major on go, then captures CNN_TOP's result or times out.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en_i     : host write strobe (accepted only in IDLE)
//   wr_addr_i   : pixel index y*IMG_W+x
//   wr_data_i   : pixel value
//   go_i        : start a frame transfer (sampled in IDLE)
//   busy_o      : high in every state but IDLE
//   done_o      : 1-cycle pulse on result capture or timeout
//   result_o    : captured signed result, held until next accepted go
//   timeout_o   : sticky timeout flag, cleared on accepted go
//   wr_err_o    : sticky write-while-busy flag, cleared on accepted go
//   cnn_bus     : master side of the CNN_TOP link
module cnn_frame_streamer
  import cnn_frame_streamer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  pix_t                        wr_data_i,
  input  logic                        go_i,
  output logic                        busy_o,
  output logic                        done_o,
  output result_t                     result_o,
  output logic                        timeout_o,
  output logic                        wr_err_o,
  cnn_frame_streamer_if.master        cnn_bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);

  strm_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              start_q, start_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  result_t           result_q, result_d;
  logic              timeout_q, timeout_d;
  logic              wr_err_q, wr_err_d;

  logic              ram_we_c;
  logic              ram_re_c;
  wr_req_t           ram_wr_c;
  pix_t              rd_pix;

  // Host writes only land while idle; reads run during prefetch and streaming.
  assign ram_we_c = wr_en_i && (state_q == IDLE);
  assign ram_re_c = (state_q == PREF) || (state_q == STREAM);
  assign ram_wr_c = '{addr: wr_addr_i, data: wr_data_i};

  cnn_frame_ram u_ram (
    .clk       (clk),
    .we_i      (ram_we_c),
    .wr_i      (ram_wr_c),
    .re_i      (ram_re_c),
    .rd_addr_i (cnt_q[ADDR_W-1:0]),
    .rd_data_o (rd_pix)
  );

  // Next-state and output logic. In STREAM cnt_q is the address being
  // fetched, one ahead of the pixel on the bus.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    start_d   = 1'b0;
    vld_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    timeout_d = timeout_q;
    wr_err_d  = wr_err_q;

    if (wr_en_i && (state_q != IDLE)) wr_err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          state_d   = START;
          start_d   = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          wcnt_d    = '0;
          result_d  = '0;
          timeout_d = 1'b0;
          wr_err_d  = 1'b0;
        end
      end
      START: state_d = PREF;
      PREF: begin
        state_d = STREAM;
        vld_d   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      STREAM: begin
        if (cnt_q == CNT_W'(N_PIX)) begin
          state_d = WAIT_RES;
          wcnt_d  = '0;
        end else begin
          vld_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RES: begin
        // A result arriving on the final wait cycle beats the timeout.
        if (cnn_bus.cnn_result_valid) begin
          state_d  = IDLE;
          result_d = cnn_bus.cnn_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else if (wcnt_q + WCNT_W'(1) == WCNT_W'(TIMEOUT_CYC)) begin
          state_d   = IDLE;
          result_d  = '0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      start_q   <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      start_q   <= start_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign timeout_o = timeout_q;
  assign wr_err_o  = wr_err_q;

  // Pixel bus is forced to 0 between beats (RAM output is not reset).
  assign cnn_bus.cnn_start       = start_q;
  assign cnn_bus.cnn_pixel_valid = vld_q;
  assign cnn_bus.cnn_pixel       = vld_q ? rd_pix : '0;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed/randomized bench for cnn_frame_streamer against a frame-array model.
module tb_cnn_frame_streamer;
  import cnn_frame_streamer_pkg::*;

  localparam int unsigned TO_B  = 100;
  localparam int          L_LBL = N_PIX + 2;  // label of the last pixel beat after go

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              go;
  logic              busy, done, timeout, wr_err;
  logic [RES_W-1:0]  result;

  logic              wr_en_b, go_b;
  logic              busy_b, done_b, timeout_b, wr_err_b;
  logic [RES_W-1:0]  result_b;

  logic [PIX_W-1:0]  ref_mem [N_PIX];
  logic [PIX_W-1:0]  got     [N_PIX];
  int                n_cmp;
  int                n_fail;

  cnn_frame_streamer_if bus_a ();
  cnn_frame_streamer_if bus_b ();

  cnn_frame_streamer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .go_i      (go),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .timeout_o (timeout),
    .wr_err_o  (wr_err),
    .cnn_bus   (bus_a.master)
  );

  cnn_frame_streamer #(.TIMEOUT_CYC(TO_B)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_b),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .go_i      (go_b),
    .busy_o    (busy_b),
    .done_o    (done_b),
    .result_o  (result_b),
    .timeout_o (timeout_b),
    .wr_err_o  (wr_err_b),
    .cnn_bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus_a.cnn_start, bus_a.cnn_pixel_valid, bus_a.cnn_pixel,
                busy, done, timeout, wr_err, result});
  endfunction

  task automatic load_frame(input logic pattern);
    for (int i = 0; i < int'(N_PIX); i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = pattern ? PIX_W'(100 + ((i % int'(IMG_W)) ^ (i / int'(IMG_W))))
                        : PIX_W'($urandom);
      ref_mem[ADDR_W'(i)] = wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // One go on u_dut. resp_c: label at which CNN answers (first wait label is
  // L_LBL+1). mode 1: go+write injected mid-stream; mode 2: reset at pixel 500.
  task automatic run_frame(input int resp_c, input logic [RES_W-1:0] resp_v, input int mode);
    int               d_lbl;
    int               beats;
    logic             exp_v;
    logic [PIX_W-1:0] exp_pix;
    d_lbl = resp_c + 1;
    beats = 0;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= d_lbl + 1; c++) begin
      exp_v   = (c >= 3) && (c <= L_LBL);
      exp_pix = exp_v ? ref_mem[ADDR_W'(c - 3)] : '0;
      check("beat",
            64'({bus_a.cnn_start, bus_a.cnn_pixel_valid, bus_a.cnn_pixel, busy, done, wr_err}),
            64'({c == 1, exp_v, exp_pix, c < d_lbl, c == d_lbl, (mode == 1) && (c > 600)}));
      if (c == 1) check("clr_on_go", 64'({timeout, result}), 64'(0));
      if (c == d_lbl) begin
        check("result", 64'(result), 64'(resp_v));
        check("timeout_clr", 64'(timeout), 64'(0));
      end
      if (bus_a.cnn_pixel_valid && beats < int'(N_PIX)) begin
        got[ADDR_W'(beats)] = bus_a.cnn_pixel;
        beats++;
      end
      if (mode == 2 && c == 503) begin
        bus_a.cnn_result_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst", all_out(), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (mode == 1 && c == 600) begin
        go      = 1'b1;
        wr_en   = 1'b1;
        wr_addr = ADDR_W'($urandom_range(0, N_PIX - 1));
        wr_data = ~ref_mem[wr_addr];
      end
      if (mode == 1 && c == 601) begin
        go    = 1'b0;
        wr_en = 1'b0;
      end
      bus_a.cnn_result_valid = (c == resp_c) || (c == 10);
      bus_a.cnn_result       = (c == resp_c) ? resp_v : RES_W'({$urandom, $urandom});
      @(negedge clk);
    end
    bus_a.cnn_result_valid = 1'b0;
    check("beat_count", 64'(beats), 64'(N_PIX));
  endtask

  // One go on u_dut_b (short timeout). simul: answer on the last wait cycle.
  task automatic run_b(input logic simul, input logic [RES_W-1:0] v);
    int d_lbl;
    d_lbl = L_LBL + 1 + int'(TO_B);
    go_b  = 1'b1;
    @(negedge clk);
    go_b  = 1'b0;
    for (int c = 1; c <= d_lbl + 1; c++) begin
      check("b_ctl", 64'({busy_b, done_b, timeout_b}),
            64'({c < d_lbl, c == d_lbl, (c >= d_lbl) && !simul}));
      if (c == d_lbl) check("b_result", 64'(result_b), simul ? 64'(v) : 64'(0));
      bus_b.cnn_result_valid = simul && (c == d_lbl - 1);
      bus_b.cnn_result       = v;
      @(negedge clk);
    end
    bus_b.cnn_result_valid = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    go      = 1'b0;
    wr_en_b = 1'b0;
    go_b    = 1'b0;
    bus_a.cnn_result_valid = 1'b0;
    bus_a.cnn_result       = '0;
    bus_b.cnn_result_valid = 1'b0;
    bus_b.cnn_result       = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset", all_out(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", all_out(), 64'(0));

    // Pattern frame, result 200 cycles after the last pixel
    load_frame(1'b1);
    run_frame(L_LBL + 200, 48'sd68264, 0);
    check("pix0",    64'(got[0]),    64'(100));
    check("pix31",   64'(got[31]),   64'(131));
    check("pix33",   64'(got[33]),   64'(100));
    check("pix1023", 64'(got[1023]), 64'(100));
    check("res68264", 64'(result), 64'(68264));

    // Reset mid-stream, then restart with frame intact
    run_frame(L_LBL + 10, '0, 2);
    run_frame(L_LBL + 50, RES_W'({$urandom, $urandom}), 0);
    check("restart_pix0", 64'(got[0]), 64'(100));

    // Random frame; negative result on the first wait cycle
    load_frame(1'b0);
    run_frame(L_LBL + 1, 48'hFFFF_FFFF_FFFB, 0);
    check("neg_result", 64'(result), 64'(48'hFFFF_FFFF_FFFB));

    // go and write while streaming are ignored / flagged
    run_frame(L_LBL + $urandom_range(1, 40), RES_W'({$urandom, $urandom}), 1);
    check("wr_err_sticky", 64'(wr_err), 64'(1));
    run_frame(L_LBL + $urandom_range(1, 40), RES_W'({$urandom, $urandom}), 0);

    // Write and go in the same idle cycle
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 8'hAA;
    ref_mem[0] = 8'hAA;
    run_frame(L_LBL + 5, RES_W'({$urandom, $urandom}), 0);
    check("wr_go_pix0", 64'(got[0]), 64'(8'hAA));

    // Timeout and result-versus-timeout tie on the short-timeout instance
    run_b(1'b0, '0);
    run_b(1'b1, RES_W'({$urandom, $urandom}) | 48'h1);

    // A few more random frames with random response delays
    for (int k = 0; k < 2; k++) begin
      load_frame(1'b0);
      run_frame(L_LBL + $urandom_range(1, 300), RES_W'({$urandom, $urandom}), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
